// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding ibus reads,
// one-entry output buffer to decode, redirect handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             ireq_valid,
  output logic [31:0]      ireq_addr,
  input  logic             ireq_ready,
  input  logic             iresp_valid,
  input  logic [31:0]      iresp_data,
  input  logic             decode_enable,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             fetch_valid,
  output logic [31:0]      fetch_pc,
  output logic [31:0]      fetch_instruction,
  output logic             fetch_jump,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FLUSH
  } state_t;

  state_t           state, state_d;
  logic [31:0]      pc, pc_d;
  logic             valid_d;
  logic [31:0]      fpc_d;
  logic [31:0]      finst_d;
  logic             fjump_d;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      target;
  logic             is_jump;

  assign target  = {redirect_pc[31:2], 2'b00};
  assign is_jump = (iresp_data[31:26] == 6'h02) ||
                   (iresp_data[31:26] == 6'h03);

  // resetn gating keeps the request low while reset is held
  assign ireq_valid = resetn && (state == S_REQ);
  assign ireq_addr  = pc;

  always_comb begin
    state_d = state;
    pc_d    = pc;
    valid_d = fetch_valid;
    fpc_d   = fetch_pc;
    finst_d = fetch_instruction;
    fjump_d = fetch_jump;
    cnt_d   = fetch_count;
    case (state)
      S_REQ: begin
        if (ireq_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (iresp_valid) begin
          state_d = S_HOLD;
          valid_d = 1'b1;
          fpc_d   = pc;
          finst_d = iresp_data;
          fjump_d = is_jump;
          pc_d    = pc + 32'd4;
        end
      end
      S_HOLD: begin
        if (decode_enable) begin
          state_d = S_REQ;
          valid_d = 1'b0;
          cnt_d   = fetch_count + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (iresp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    // redirect overrides everything; pc doubles as the flush target
    if (redirect_valid) begin
      pc_d    = target;
      valid_d = 1'b0;
      fpc_d   = fetch_pc;
      finst_d = fetch_instruction;
      fjump_d = fetch_jump;
      cnt_d   = fetch_count;
      case (state)
        S_REQ:   state_d = ireq_ready ? S_FLUSH : S_REQ;
        S_WAIT:  state_d = iresp_valid ? S_REQ : S_FLUSH;
        S_HOLD:  state_d = S_REQ;
        S_FLUSH: state_d = iresp_valid ? S_REQ : S_FLUSH;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= S_REQ;
      pc                <= RESET_PC;
      fetch_valid       <= 1'b0;
      fetch_pc          <= '0;
      fetch_instruction <= '0;
      fetch_jump        <= 1'b0;
      fetch_count       <= '0;
    end else begin
      state             <= state_d;
      pc                <= pc_d;
      fetch_valid       <= valid_d;
      fetch_pc          <= fpc_d;
      fetch_instruction <= finst_d;
      fetch_jump        <= fjump_d;
      fetch_count       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed steps then random
// transactions against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        decode_enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instruction;
  logic        fetch_jump;
  logic [31:0] fetch_count;

  fetch_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ireq_valid        (ireq_valid),
    .ireq_addr         (ireq_addr),
    .ireq_ready        (ireq_ready),
    .iresp_valid       (iresp_valid),
    .iresp_data        (iresp_data),
    .decode_enable     (decode_enable),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .fetch_instruction (fetch_instruction),
    .fetch_jump        (fetch_jump),
    .fetch_count       (fetch_count)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  // model: address of the next fetch and instructions delivered
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_j(input logic [31:0] d);
    return d[31:26] == 6'd2 || d[31:26] == 6'd3;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (ireq_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", ireq_valid, 1);
    chk("req_addr", ireq_addr, exp_pc);
  endtask

  task automatic issue(input int lat);
    repeat (lat) begin
      chk("req_stable", ireq_addr, exp_pc);
      @(negedge clk);
    end
    chk("req_stable_v", ireq_valid, 1);
    ireq_ready = 1'b1;
    @(negedge clk);
    ireq_ready = 1'b0;
    chk("wait_noreq", ireq_valid, 0);
  endtask

  task automatic respond(input logic [31:0] d, input int lat);
    repeat (lat) begin
      chk("resp_noreq", ireq_valid, 0);
      chk("resp_nofv", fetch_valid, 0);
      @(negedge clk);
    end
    iresp_valid = 1'b1;
    iresp_data  = d;
    @(negedge clk);
    iresp_valid = 1'b0;
    iresp_data  = $urandom;
  endtask

  task automatic present(input logic [31:0] d);
    chk("fv", fetch_valid, 1);
    chk("fpc", fetch_pc, exp_pc);
    chk("finst", fetch_instruction, d);
    chk("fjump", fetch_jump, is_j(d));
  endtask

  task automatic take(input logic [31:0] d, input int hold);
    repeat (hold) begin
      decode_enable = 1'b0;
      @(negedge clk);
      present(d);
      chk("hold_noreq", ireq_valid, 0);
      chk("hold_cnt", fetch_count, exp_count);
    end
    decode_enable = 1'b1;
    @(negedge clk);
    decode_enable = 1'b0;
    exp_count = exp_count + 1;
    exp_pc    = exp_pc + 32'd4;
    chk("take_fv", fetch_valid, 0);
    chk("take_cnt", fetch_count, exp_count);
    chk("next_req", ireq_valid, 1);
    chk("next_addr", ireq_addr, exp_pc);
  endtask

  task automatic fetch(input logic [31:0] d, input int rl,
                       input int pl, input int hold);
    wait_req();
    issue(rl);
    respond(d, pl);
    present(d);
    take(d, hold);
  endtask

  task automatic redir_hold(input logic [31:0] d, input logic [31:0] t);
    wait_req();
    issue($urandom_range(0, 2));
    respond(d, $urandom_range(0, 2));
    present(d);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    decode_enable  = 1'($urandom);
    @(negedge clk);
    redirect_valid = 1'b0;
    decode_enable  = 1'b0;
    exp_pc = {t[31:2], 2'b00};
    chk("rh_fv", fetch_valid, 0);
    chk("rh_cnt", fetch_count, exp_count);
    chk("rh_req", ireq_valid, 1);
    chk("rh_addr", ireq_addr, exp_pc);
  endtask

  task automatic redir_wait(input logic [31:0] t, input logic [31:0] t2,
                            input logic twice, input int lat);
    wait_req();
    issue($urandom_range(0, 2));
    redirect_valid = 1'b1;
    redirect_pc    = t;
    @(negedge clk);
    exp_pc = {t[31:2], 2'b00};
    redirect_valid = 1'b0;
    if (twice) begin
      redirect_valid = 1'b1;
      redirect_pc    = t2;
      @(negedge clk);
      redirect_valid = 1'b0;
      exp_pc = {t2[31:2], 2'b00};
    end
    respond($urandom, lat);
    chk("rw_fv", fetch_valid, 0);
    chk("rw_cnt", fetch_count, exp_count);
    wait_req();
  endtask

  task automatic redir_wait_resp(input logic [31:0] t);
    wait_req();
    issue($urandom_range(0, 2));
    redirect_valid = 1'b1;
    redirect_pc    = t;
    iresp_valid    = 1'b1;
    iresp_data     = $urandom;
    @(negedge clk);
    redirect_valid = 1'b0;
    iresp_valid    = 1'b0;
    exp_pc = {t[31:2], 2'b00};
    chk("rwr_fv", fetch_valid, 0);
    chk("rwr_req", ireq_valid, 1);
    chk("rwr_addr", ireq_addr, exp_pc);
  endtask

  task automatic redir_req(input logic [31:0] t, input logic rdy);
    wait_req();
    redirect_valid = 1'b1;
    redirect_pc    = t;
    ireq_ready     = rdy;
    @(negedge clk);
    redirect_valid = 1'b0;
    ireq_ready     = 1'b0;
    exp_pc = {t[31:2], 2'b00};
    chk("rq_fv", fetch_valid, 0);
    if (rdy) begin
      chk("rq_flush", ireq_valid, 0);
      respond($urandom, $urandom_range(0, 3));
      chk("rq_fv2", fetch_valid, 0);
    end
    chk("rq_req", ireq_valid, 1);
    chk("rq_addr", ireq_addr, exp_pc);
  endtask

  initial begin
    resetn         = 1'b0;
    ireq_ready     = 1'b0;
    iresp_valid    = 1'b0;
    iresp_data     = '0;
    decode_enable  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exp_pc         = RST_PC;
    exp_count      = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_reqv", ireq_valid, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_fpc", fetch_pc, 0);
    chk("rst_finst", fetch_instruction, 0);
    chk("rst_fjump", fetch_jump, 0);
    chk("rst_cnt", fetch_count, 0);
    resetn = 1'b1;

    fetch(32'h2402_0001, 0, 0, 0);
    fetch($urandom, 1, 1, 5);
    redir_hold(32'h0800_0010, 32'h8000_0040);
    redir_wait(32'h8000_0103, 32'h0, 1'b0, 2);
    redir_req(32'hffff_fffc, 1'b0);
    fetch(32'h0c00_0123, 0, 0, 1);
    redir_wait_resp(32'h1234_5679);
    redir_req(32'h0000_1002, 1'b1);
    redir_wait(32'h4000_0000, 32'h5000_000b, 1'b1, 1);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] d;
      logic [31:0] t;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d[31:26] = 6'($urandom_range(2, 3));
      t = $urandom;
      case ($urandom_range(0, 6))
        0, 1: fetch(d, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
        2: redir_hold(d, t);
        3: redir_wait(t, $urandom, 1'($urandom), $urandom_range(0, 3));
        4: redir_wait_resp(t);
        5: redir_req(t, 1'b1);
        default: redir_req(t, 1'b0);
      endcase
    end

    fetch($urandom, 0, 0, 0);
    wait_req();
    issue(0);
    resetn = 1'b0;
    #1;
    chk("arst_fv", fetch_valid, 0);
    chk("arst_cnt", fetch_count, 0);
    chk("arst_reqv", ireq_valid, 0);
    chk("arst_fpc", fetch_pc, 0);
    @(negedge clk);
    resetn    = 1'b1;
    exp_pc    = RST_PC;
    exp_count = '0;
    fetch(32'h0800_0001, 0, 1, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
